// File: rtl/i2s_pkg.sv
// Shared constants and frame packing helper for the WM8731 DAC serializer.
// Frames are MSB-aligned in a 64-bit word so any SLOT_W up to 32 shares one shifter.
package i2s_pkg;

    localparam int MODE_LJ   = 0;
    localparam int MODE_I2S  = 1;
    localparam int MAX_W     = 32;
    localparam int FRAME_MAX = 2 * MAX_W;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Left slot occupies the top slot_w bits, right slot follows; samples
    // sit MSB-first in their slot with zero padding after.
    function automatic logic [FRAME_MAX-1:0] frame_pack(
        input logic [MAX_W-1:0] left,
        input logic [MAX_W-1:0] right,
        input logic             mono,
        input int               data_w,
        input int               slot_w
    );
        logic [MAX_W-1:0]     l_word;
        logic [MAX_W-1:0]     r_word;
        logic [FRAME_MAX-1:0] frame;
        l_word = left << (MAX_W - data_w);
        r_word = (mono ? left : right) << (MAX_W - data_w);
        frame  = {l_word, {MAX_W{1'b0}}} | ({r_word, {MAX_W{1'b0}}} >> slot_w);
        return frame;
    endfunction

endpackage

// File: rtl/i2s_dac_tx_fifo.sv
// Synchronous sample-pair FIFO; head entry is always visible on rd_data.
module sample_fifo
    import i2s_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [WIDTH-1:0]          rd_data,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo DAC serializer: oversampled bclk/lrck, per-frame FIFO pop, LJ or I2S framing.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MODE       = MODE_LJ
) (
    input  logic                           clock_50M,
    input  logic                           reset,
    input  logic                           bclk,
    input  logic                           lrck,
    input  logic                           play_en,
    input  logic                           mono,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic [DATA_W-1:0]              s_left,
    input  logic [DATA_W-1:0]              s_right,
    output logic                           dacdat,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic                           underrun,
    output logic [15:0]                    underrun_cnt
);

    localparam int FRAME_BITS = 2 * SLOT_W;
    localparam int CNT_W      = $clog2(FRAME_MAX + 1);

    logic                    bclk_a, bclk_b;
    logic                    lrck_a, lrck_b;
    logic                    frame_start;
    logic                    bit_tick;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    push;
    logic                    pop;
    logic [2*DATA_W-1:0]     head;
    logic [FRAME_MAX-1:0]    frame_load;
    logic [FRAME_MAX-1:0]    shreg;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    dacdat_q;
    logic                    underrun_q;
    logic [15:0]             underrun_cnt_q;

    always_ff @(posedge clock_50M) begin
        if (reset) begin
            bclk_a <= 1'b0;
            bclk_b <= 1'b0;
            lrck_a <= 1'b0;
            lrck_b <= 1'b0;
        end else begin
            bclk_a <= bclk;
            bclk_b <= bclk_a;
            lrck_a <= lrck;
            lrck_b <= lrck_a;
        end
    end

    assign frame_start = lrck_a & ~lrck_b;
    assign bit_tick    = ~bclk_a & bclk_b;

    assign s_ready = ~fifo_full;
    assign push    = s_valid & ~fifo_full;
    assign pop     = frame_start & play_en & ~fifo_empty;

    sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock_50M),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data ({s_left, s_right}),
        .rd_data (head),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        frame_load = '0;
        if (pop) begin
            frame_load = frame_pack(MAX_W'(head[2*DATA_W-1:DATA_W]),
                                    MAX_W'(head[DATA_W-1:0]),
                                    mono, DATA_W, SLOT_W);
        end
    end

    // bit_cnt counts bits already presented on dacdat; in LJ mode the MSB
    // goes out with the load, so the count starts at one.
    always_ff @(posedge clock_50M) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            dacdat_q <= 1'b0;
        end else if (frame_start) begin
            if (MODE == MODE_LJ) begin
                dacdat_q <= frame_load[FRAME_MAX-1];
                shreg    <= {frame_load[FRAME_MAX-2:0], 1'b0};
                bit_cnt  <= CNT_W'(1);
            end else begin
                dacdat_q <= 1'b0;
                shreg    <= frame_load;
                bit_cnt  <= '0;
            end
        end else if (bit_tick) begin
            if (bit_cnt < CNT_W'(FRAME_BITS)) begin
                dacdat_q <= shreg[FRAME_MAX-1];
                shreg    <= {shreg[FRAME_MAX-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 1'b1;
            end else begin
                dacdat_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock_50M) begin
        if (reset) begin
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            underrun_q <= 1'b0;
            if (frame_start && play_en && fifo_empty) begin
                underrun_q <= 1'b1;
                if (underrun_cnt_q != '1) begin
                    underrun_cnt_q <= underrun_cnt_q + 1'b1;
                end
            end
        end
    end

    assign dacdat       = dacdat_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench: MODE 0 and MODE 1 instances driven in lockstep from one stimulus.
module tb_i2s_dac_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        bclk;
    logic        lrck;
    logic        play_en;
    logic        mono;
    logic        s_valid;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        s_ready0, s_ready1;
    logic        dacdat0, dacdat1;
    logic [2:0]  level0, level1;
    logic        underrun0, underrun1;
    logic [15:0] ucnt0, ucnt1;

    int compared   = 0;
    int mismatched = 0;
    int ur_seen;
    logic [63:0] cap0, cap1;
    logic        tail0;

    always #5 clk = ~clk;

    i2s_dac_tx #(.DATA_W(16), .SLOT_W(32), .FIFO_DEPTH(4), .MODE(0)) dut0 (
        .clock_50M(clk), .reset(reset), .bclk(bclk), .lrck(lrck),
        .play_en(play_en), .mono(mono), .s_valid(s_valid), .s_ready(s_ready0),
        .s_left(s_left), .s_right(s_right), .dacdat(dacdat0),
        .fifo_level(level0), .underrun(underrun0), .underrun_cnt(ucnt0)
    );

    i2s_dac_tx #(.DATA_W(16), .SLOT_W(32), .FIFO_DEPTH(4), .MODE(1)) dut1 (
        .clock_50M(clk), .reset(reset), .bclk(bclk), .lrck(lrck),
        .play_en(play_en), .mono(mono), .s_valid(s_valid), .s_ready(s_ready1),
        .s_left(s_left), .s_right(s_right), .dacdat(dacdat1),
        .fifo_level(level1), .underrun(underrun1), .underrun_cnt(ucnt1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            if (underrun0) ur_seen++;
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
    endtask

    // One 64-bit frame (lrck rises with the first bclk fall) plus one spare bit.
    task automatic run_frame();
        ur_seen = 0;
        for (int i = 0; i < 64; i++) begin
            bclk = 1'b0;
            if (i == 0)  lrck = 1'b1;
            if (i == 32) lrck = 1'b0;
            tick(8);
            bclk = 1'b1;
            tick(4);
            cap0[63-i] = dacdat0;
            cap1[63-i] = dacdat1;
            tick(4);
        end
        bclk = 1'b0;
        tick(8);
        bclk = 1'b1;
        tick(4);
        tail0 = dacdat0;
        tick(4);
    endtask

    function automatic logic [63:0] lj(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    initial begin
        reset   = 1'b1;
        bclk    = 1'b1;
        lrck    = 1'b0;
        play_en = 1'b1;
        mono    = 1'b0;
        s_valid = 1'b0;
        s_left  = '0;
        s_right = '0;
        tick(4);
        check("rst_dacdat", 64'(dacdat0), 64'd0);
        check("rst_ready", 64'(s_ready0), 64'd1);
        check("rst_level", 64'(level0), 64'd0);
        check("rst_underrun", 64'(underrun0), 64'd0);
        check("rst_cnt", 64'(ucnt0), 64'd0);
        reset = 1'b0;
        tick(4);

        // Basic left-justified and I2S frame
        push(16'hA5C3, 16'h0F01);
        check("push_level", 64'(level0), 64'd1);
        run_frame();
        check("lj_frame", cap0, 64'hA5C3_0000_0F01_0000);
        check("i2s_frame", cap1, {1'b0, 63'h52E1_8000_0780_8000});
        check("lj_tail_zero", 64'(tail0), 64'd0);
        check("pop_level", 64'(level0), 64'd0);
        check("no_underrun", 64'(ur_seen), 64'd0);

        // Underrun then recovery
        run_frame();
        check("ur_frame", cap0, 64'd0);
        check("ur_pulse", 64'(ur_seen), 64'd1);
        check("ur_cnt1", 64'(ucnt0), 64'd1);
        push(16'h1234, 16'h5678);
        run_frame();
        check("recover_frame", cap0, 64'h1234_0000_5678_0000);

        // Fill beyond depth
        for (int k = 1; k <= 4; k++) push(16'h1100 + 16'(k), 16'h2200 + 16'(k));
        check("full_ready", 64'(s_ready0), 64'd0);
        check("full_level", 64'(level0), 64'd4);
        s_left  = 16'h1105;
        s_right = 16'h2205;
        s_valid = 1'b1;
        tick(5);
        check("held_level", 64'(level0), 64'd4);
        run_frame();
        s_valid = 1'b0;
        check("full_pop_frame", cap0, lj(16'h1101, 16'h2201));
        check("refill_level", 64'(level0), 64'd4);
        for (int k = 2; k <= 5; k++) begin
            run_frame();
            check($sformatf("drain_%0d", k), cap0, lj(16'h1100 + 16'(k), 16'h2200 + 16'(k)));
        end
        check("drained_level", 64'(level0), 64'd0);

        // Mono duplication
        mono = 1'b1;
        push(16'h8001, 16'h7FFF);
        run_frame();
        mono = 1'b0;
        check("mono_frame", cap0, 64'h8001_0000_8001_0000);

        // play_en gate
        play_en = 1'b0;
        push(16'h3C3C, 16'hC3C3);
        run_frame();
        check("gated_frame", cap0, 64'd0);
        check("gated_level", 64'(level0), 64'd1);
        check("gated_no_ur", 64'(ur_seen), 64'd0);
        check("gated_cnt", 64'(ucnt0), 64'd1);
        play_en = 1'b1;
        run_frame();
        check("ungated_frame", cap0, 64'h3C3C_0000_C3C3_0000);

        // Reset mid-frame at bit 20
        push(16'hFFFF, 16'hFFFF);
        push(16'hAAAA, 16'h5555);
        for (int i = 0; i < 20; i++) begin
            bclk = 1'b0;
            if (i == 0) lrck = 1'b1;
            tick(8);
            bclk = 1'b1;
            tick(8);
        end
        bclk = 1'b0;
        tick(4);
        check("pre_rst_level", 64'(level0), 64'd1);
        reset = 1'b1;
        tick(1);
        check("midrst_dacdat", 64'(dacdat0), 64'd0);
        check("midrst_level", 64'(level0), 64'd0);
        check("midrst_cnt", 64'(ucnt0), 64'd0);
        lrck = 1'b0;
        bclk = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(4);

        // Saturating underrun counter
        force dut0.underrun_cnt_q = 16'hFFFE;
        tick(1);
        release dut0.underrun_cnt_q;
        tick(1);
        check("forced_cnt", 64'(ucnt0), 64'hFFFE);
        for (int k = 0; k < 3; k++) begin
            run_frame();
            check($sformatf("sat_pulse_%0d", k), 64'(ur_seen), 64'd1);
            check($sformatf("sat_cnt_%0d", k), 64'(ucnt0), 64'hFFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
